// File: rtl/cordic_pair_sequencer.sv
// cordic_pair_sequencer: operand FIFO + issue/collect FSM around a two-input
// CORDIC+adder core. One operation in flight at a time. Data passes bit-exact.
// Optional build macro CORDIC_SEQ_TIMEOUT_EN adds a WAIT watchdog that aborts
// with a qNaN result and sets a sticky err_timeout flag.
module cordic_pair_sequencer #(
  parameter int DEPTH          = 4,
  parameter int LOG2_DEPTH     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_dataa,
  input  logic [31:0]           in_datab,
  output logic [31:0]           core_dataa,
  output logic [31:0]           core_datab,
  output logic                  core_start,
  input  logic                  core_done,
  input  logic [31:0]           core_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_result,
  output logic [LOG2_DEPTH:0]   fifo_count,
  output logic                  busy,
  output logic                  err_timeout
);

  // Elaboration-time sanity on the configuration.
  if (DEPTH != (1 << LOG2_DEPTH) || DEPTH < 2)
    $error("DEPTH must be a power of two >= 2 matching LOG2_DEPTH");
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535)
    $error("TIMEOUT_CYCLES out of range 1..65535");

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t                       state, state_nxt;
  logic [1:0]                   rst_sync;
  logic                         rst_n;
  logic [DEPTH-1:0][31:0]       mem_a, mem_b;
  logic [LOG2_DEPTH-1:0]        wr_ptr, rd_ptr;
  logic                         push, pop, tmo_hit;

  // Reset asserts asynchronously, releases two clocks after reset_n rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Count never exceeds DEPTH, so the top bit alone means full.
  assign in_ready   = !fifo_count[LOG2_DEPTH];
  assign push       = in_valid && in_ready;
  assign pop        = (state == S_IDLE) && (fifo_count != '0) && !out_valid;
  assign core_start = (state == S_ISSUE);
  assign busy       = (state != S_IDLE) || (fifo_count != '0);

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_dataa;
      mem_b[wr_ptr] <= in_datab;
    end
  end

  // FIFO pointers and occupancy; pointers wrap by width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LOG2_DEPTH'(1);
      if (pop)  rd_ptr <= rd_ptr + LOG2_DEPTH'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (LOG2_DEPTH+1)'(1);
        2'b01:   fifo_count <= fifo_count - (LOG2_DEPTH+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef CORDIC_SEQ_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // WAIT-cycle counter, cleared during ISSUE so it starts at 0 in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 tmo_cnt <= '0;
    else if (state == S_ISSUE)  tmo_cnt <= '0;
    else if (state == S_WAIT)   tmo_cnt <= tmo_cnt + 16'd1;
  end

  // Fires on the TIMEOUT_CYCLES-th WAIT cycle; a same-cycle core_done wins.
  assign tmo_hit = (state == S_WAIT) && !core_done &&
                   (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Sticky abort flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_timeout <= 1'b0;
    else if (tmo_hit) err_timeout <= 1'b1;
  end
`else
  assign tmo_hit     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; core_done is only honoured in WAIT.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pop) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (core_done || tmo_hit) state_nxt = S_HOLD;
      S_HOLD:  if (out_valid && out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand launch and result capture; nothing changes under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_dataa <= 32'h0;
      core_datab <= 32'h0;
      out_result <= 32'h0;
      out_valid  <= 1'b0;
    end else begin
      if (pop) begin
        core_dataa <= mem_a[rd_ptr];
        core_datab <= mem_b[rd_ptr];
      end
      if (state == S_WAIT && core_done) begin
        out_result <= core_result;
        out_valid  <= 1'b1;
      end else if (tmo_hit) begin
        out_result <= 32'h7FC0_0000;
        out_valid  <= 1'b1;
      end else if (state == S_HOLD && out_valid && out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule
